deflate_table_loader: RTL

DEFLATE_TABLE_LOADER -- requirements
Module: deflate_table_loader

---
 rtl/deflate_table_loader.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/deflate_table_loader.sv
// Expands a DEFLATE dynamic-block code-length symbol stream into per-index writes for the
// literal/length and distance table builders, zero-fills the unused tail, then runs both builders.
module deflate_table_loader #(
  parameter int unsigned LIT_CODES  = 288,
  parameter int unsigned DIST_CODES = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [4:0] hlit,
  input  logic [4:0] hdist,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic [4:0] sym,
  input  logic [6:0] sym_extra,
  output logic       bld_istart,
  output logic       lit_wren,
  output logic       dist_wren,
  output logic [8:0] wraddr,
  output logic [4:0] wrdata,
  output logic       lit_run,
  output logic       dist_run,
  input  logic       lit_done,
  input  logic       dist_done,
  output logic       tables_ready,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle, StClear, StLoad, StRepeat, StFill, StBuild, StReady, StError
  } state_e;

  localparam logic [8:0] LitMax  = 9'(LIT_CODES);
  localparam logic [8:0] DistMax = 9'(DIST_CODES);

  state_e     state_q, state_d;
  logic [8:0] nl_q, nl_d, nd_q, nd_d, n_q, n_d, i_q, i_d, fill_q, fill_d;
  logic       fill_dist_q, fill_dist_d;
  logic [3:0] prev_q, prev_d, rep_val_q, rep_val_d;
  logic [7:0] rep_q, rep_d;
  logic       lit_done_q, lit_done_d, dist_done_q, dist_done_d;
  logic       lit_wren_d, dist_wren_d;
  logic [8:0] wraddr_d;
  logic [4:0] wrdata_d;

  logic       wr_en;
  logic [3:0] wr_val;
  logic [7:0] rep_len;
  logic [9:0] rep_end;
  logic [3:0] rep_sel;
  logic       in_lit;
  logic [8:0] idx_addr;

  always_comb begin
    case (sym)
      5'd16:   rep_len = 8'd3 + {6'd0, sym_extra[1:0]};
      5'd17:   rep_len = 8'd3 + {5'd0, sym_extra[2:0]};
      default: rep_len = 8'd11 + {1'b0, sym_extra};
    endcase
  end

  // 10-bit sum so a long run near the end of the stream cannot wrap past N.
  assign rep_end  = {1'b0, i_q} + {2'b00, rep_len};
  assign rep_sel  = (sym == 5'd16) ? prev_q : 4'd0;
  assign in_lit   = i_q < nl_q;
  assign idx_addr = in_lit ? i_q : i_q - nl_q;

  always_comb begin
    state_d     = state_q;
    nl_d        = nl_q;
    nd_d        = nd_q;
    n_d         = n_q;
    i_d         = i_q;
    prev_d      = prev_q;
    rep_d       = rep_q;
    rep_val_d   = rep_val_q;
    fill_d      = fill_q;
    fill_dist_d = fill_dist_q;
    lit_done_d  = lit_done_q;
    dist_done_d = dist_done_q;
    wr_en       = 1'b0;
    wr_val      = 4'd0;
    lit_wren_d  = 1'b0;
    dist_wren_d = 1'b0;
    wraddr_d    = 9'd0;
    wrdata_d    = 5'd0;

    if (start) begin
      nl_d        = 9'd257 + {4'd0, hlit};
      nd_d        = {4'd0, hdist} + 9'd1;
      n_d         = nl_d + nd_d;
      i_d         = 9'd0;
      prev_d      = 4'd0;
      rep_d       = 8'd0;
      lit_done_d  = 1'b0;
      dist_done_d = 1'b0;
      state_d     = StClear;
    end else begin
      case (state_q)
        StClear: state_d = StLoad;
        StLoad: begin
          if (sym_valid) begin
            if (sym > 5'd18 || (sym == 5'd16 && i_q == 9'd0) ||
                (sym >= 5'd16 && rep_end > {1'b0, n_q})) begin
              state_d = StError;
            end else if (sym < 5'd16) begin
              wr_en  = 1'b1;
              wr_val = sym[3:0];
              prev_d = sym[3:0];
              i_d    = i_q + 9'd1;
              if (i_q + 9'd1 == n_q) begin
                state_d     = StFill;
                fill_d      = nl_q;
                fill_dist_d = 1'b0;
              end
            end else begin
              wr_en     = 1'b1;
              wr_val    = rep_sel;
              prev_d    = rep_sel;
              rep_val_d = rep_sel;
              rep_d     = rep_len - 8'd1;
              i_d       = i_q + 9'd1;
              state_d   = StRepeat;
            end
          end
        end
        StRepeat: begin
          // One idle REPEAT cycle after the last write keeps sym_ready low until t+R+1.
          if (rep_q != 8'd0) begin
            wr_en  = 1'b1;
            wr_val = rep_val_q;
            i_d    = i_q + 9'd1;
            rep_d  = rep_q - 8'd1;
          end else if (i_q == n_q) begin
            state_d     = StFill;
            fill_d      = nl_q;
            fill_dist_d = 1'b0;
          end else begin
            state_d = StLoad;
          end
        end
        StFill: begin
          if (!fill_dist_q && fill_q < LitMax) begin
            lit_wren_d = 1'b1;
            wraddr_d   = fill_q;
            fill_d     = fill_q + 9'd1;
          end else if (!fill_dist_q && nd_q < DistMax) begin
            dist_wren_d = 1'b1;
            wraddr_d    = nd_q;
            fill_d      = nd_q + 9'd1;
            fill_dist_d = 1'b1;
          end else if (fill_dist_q && fill_q < DistMax) begin
            dist_wren_d = 1'b1;
            wraddr_d    = fill_q;
            fill_d      = fill_q + 9'd1;
          end else begin
            state_d = StBuild;
          end
        end
        StBuild: begin
          lit_done_d  = lit_done_q | lit_done;
          dist_done_d = dist_done_q | dist_done;
          if (lit_done_d && dist_done_d) state_d = StReady;
        end
        default: ;
      endcase

      if (wr_en) begin
        lit_wren_d  = in_lit;
        dist_wren_d = !in_lit;
        wraddr_d    = idx_addr;
        wrdata_d    = {1'b0, wr_val};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      nl_q         <= 9'd0;
      nd_q         <= 9'd0;
      n_q          <= 9'd0;
      i_q          <= 9'd0;
      prev_q       <= 4'd0;
      rep_q        <= 8'd0;
      rep_val_q    <= 4'd0;
      fill_q       <= 9'd0;
      fill_dist_q  <= 1'b0;
      lit_done_q   <= 1'b0;
      dist_done_q  <= 1'b0;
      sym_ready    <= 1'b0;
      bld_istart   <= 1'b0;
      lit_wren     <= 1'b0;
      dist_wren    <= 1'b0;
      wraddr       <= 9'd0;
      wrdata       <= 5'd0;
      lit_run      <= 1'b0;
      dist_run     <= 1'b0;
      tables_ready <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      nl_q         <= nl_d;
      nd_q         <= nd_d;
      n_q          <= n_d;
      i_q          <= i_d;
      prev_q       <= prev_d;
      rep_q        <= rep_d;
      rep_val_q    <= rep_val_d;
      fill_q       <= fill_d;
      fill_dist_q  <= fill_dist_d;
      lit_done_q   <= lit_done_d;
      dist_done_q  <= dist_done_d;
      sym_ready    <= state_d == StLoad;
      bld_istart   <= state_d == StClear;
      lit_wren     <= lit_wren_d;
      dist_wren    <= dist_wren_d;
      wraddr       <= wraddr_d;
      wrdata       <= wrdata_d;
      lit_run      <= state_d == StBuild || state_d == StReady;
      dist_run     <= state_d == StBuild || state_d == StReady;
      tables_ready <= state_d == StReady;
      err          <= state_d == StError;
    end
  end

endmodule
